// File: rtl/arb_pkg.sv
// Shared types and width helpers for the arbiter requester agent.
// The optional request timeout is built in with ARB_REQ_TIMEOUT_EN.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_req_state_t;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Word FIFO buffering local writes until the requester wins a grant.
// Power-of-two depth so pointers wrap naturally; head is the next word to send.
module arb_req_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for one arbiter channel: buffers writes, requests, bursts on grant.
// Define ARB_REQ_TIMEOUT_EN to abandon a request after REQ_TIMEOUT cycles without grant.
import arb_pkg::*;

module arb_requester #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned REQ_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    input  logic              bus_ready,
    output logic              timeout_err,
    output arb_req_state_t    state
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = bits_for(MAX_BURST - 1);

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [BEAT_W-1:0] beat;
    logic              push;
    logic              pop;
    logic              burst_end;

    // Handshakes: a write moves on wr_valid && wr_ready, a beat moves on bus_valid && bus_ready;
    // neither side may withdraw a presented beat, so head stays put until the transfer edge.
    assign wr_ready  = !fifo_full;
    assign push      = wr_valid && wr_ready;
    assign bus_valid = (state == XFER) && gnt && !fifo_empty;
    assign burst_end = (beat == BEAT_W'(MAX_BURST - 1));
    assign bus_last  = bus_valid && (burst_end || fifo_count == CNT_W'(1));
    assign bus_data  = fifo_head;
    assign pop       = bus_valid && bus_ready;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .data  (wr_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned TO_W = bits_for(REQ_TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_flag;

    assign timeout_err = timeout_flag;
`else
    // Timeout depth only matters when the timeout feature is built in.
    localparam int unsigned unused_req_timeout = REQ_TIMEOUT;

    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req   <= 1'b0;
            beat  <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (!fifo_empty) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        state <= XFER;
                        beat  <= '0;
                    end
`ifdef ARB_REQ_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(REQ_TIMEOUT - 1)) begin
                        state        <= RELEASE;
                        req          <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                XFER: begin
                    // A revoked grant ends the tenure; the unsent words retry via IDLE.
                    if (!gnt) begin
                        state <= RELEASE;
                        req   <= 1'b0;
                    end else if (pop) begin
                        beat <= beat + BEAT_W'(1);
                        if (bus_last) begin
                            state <= RELEASE;
                            req   <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    // Grant lags our req drop by a cycle; wait it out before re-requesting.
                    if (!gnt) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a one-cycle-lag arbiter model and beat scoreboard.
// Builds with or without ARB_REQ_TIMEOUT_EN; the timeout scenario runs only when it is defined.
module tb_arb_requester;
  import arb_pkg::*;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 8;
  localparam int MAX_BURST   = 4;
  localparam int REQ_TIMEOUT = 64;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              bus_ready;
  logic              timeout_err;
  arb_req_state_t    state;

  int n_vec = 0;
  int n_err = 0;

  // {last, data} per expected beat, in bus order
  logic [DATA_W:0] exp_q[$];

  arb_requester #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .MAX_BURST   (MAX_BURST),
    .REQ_TIMEOUT (REQ_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .req         (req),
    .gnt         (gnt),
    .bus_valid   (bus_valid),
    .bus_data    (bus_data),
    .bus_last    (bus_last),
    .bus_ready   (bus_ready),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- arbiter model ----------------
  // gnt follows req one clock later; gnt_force 1 = withhold, 2 = force grant.
  logic req_s = 1'b0;
  logic req_d = 1'b0;
  int   gnt_force = 0;

  assign gnt = (gnt_force == 1) ? 1'b0 : (gnt_force == 2) ? 1'b1 : req_d;

  initial begin
    forever begin
      @(negedge clk);
      req_s = req;
      @(posedge clk);
      #1;
      req_d = rst ? 1'b0 : req_s;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected beat per bus transfer, checks stall stability.
  initial begin
    logic            stall_prev;
    logic [DATA_W-1:0] data_prev;
    logic [DATA_W:0] e;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_hold_valid", bus_valid, 1);
          check("stall_hold_data", bus_data, data_prev);
        end
        if (bus_valid && bus_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_unexpected: got data %0h expected no beat", bus_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", bus_data, e[DATA_W-1:0]);
            check("beat_last", bus_last, e[DATA_W]);
          end
        end
        stall_prev = bus_valid && !bus_ready;
        data_prev  = bus_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d, input bit expect_beat, input bit last);
    wr_valid = 1'b1;
    wr_data  = d;
    if (expect_beat) exp_q.push_back({last, d});
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_state(input string name, input arb_req_state_t s);
    for (int i = 0; i < 100 && state != s; i++) step();
    check(name, state, s);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && !bus_valid; i++) step();
    check(name, bus_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", req, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_last", bus_last, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_state", state, IDLE);
    rst = 1'b0;
    step();

    // Single word: req one edge after the write, beat two edges later, req drops after it.
    write_word(32'h0000_00A1, 1'b1, 1'b1);
    check("t1_req_wait", req, 0);
    step();
    check("t1_req_rise", req, 1);
    check("t1_no_beat", bus_valid, 0);
    step();
    check("t1_in_req", state, REQ);
    check("t1_no_beat_req", bus_valid, 0);
    step();
    check("t1_beat_valid", bus_valid, 1);
    check("t1_beat_last", bus_last, 1);
    step();
    check("t1_req_drop", req, 0);
    check("t1_release", state, RELEASE);
    wait_drain("t1_drain");
    wait_state("t1_idle", IDLE);

    // Six words: tenure of four (last on 4th), gap with req low, tenure of two.
    for (int i = 0; i < 6; i++) write_word(32'h0000_00B0 + i, 1'b1, (i == 3 || i == 5));
    wait_state("t2_release", RELEASE);
    check("t2_gap_req", req, 0);
    check("t2_gap_valid", bus_valid, 0);
    step();
    check("t2_stale_gnt", state, RELEASE);
    check("t2_gap_req2", req, 0);
    wait_drain("t2_drain");
    wait_state("t2_idle", IDLE);

    // Fill with grant withheld: full at eight, ninth write refused.
    gnt_force = 1;
    for (int i = 0; i < 8; i++) begin
      check("t3_ready", wr_ready, 1);
      write_word(32'h0000_00C0 + i, 1'b1, (i == 3 || i == 7));
    end
    check("t3_full", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = 32'h0000_00C8;
    step();
    wr_valid = 1'b0;
    check("t3_still_full", wr_ready, 0);
    check("t3_req_held", req, 1);
    check("t3_no_timeout", timeout_err, 0);
    gnt_force = 0;
    wait_drain("t3_drain");
    wait_state("t3_idle", IDLE);
    check("t3_ready_back", wr_ready, 1);

    // Bus stall for three cycles after the first beat.
    for (int i = 0; i < 4; i++) write_word(32'h0000_00D0 + i, 1'b1, (i == 3));
    wait_valid("t4_first_beat");
    step();
    bus_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_valid", bus_valid, 1);
      check("t4_stall_data", bus_data, 32'h0000_00D1);
      check("t4_stall_req", req, 1);
      step();
    end
    bus_ready = 1'b1;
    wait_drain("t4_drain");
    wait_state("t4_idle", IDLE);

    // Grant revoked after one beat, then held high two cycles in RELEASE.
    write_word(32'h0000_00E0, 1'b1, 1'b0);
    write_word(32'h0000_00E1, 1'b1, 1'b0);
    write_word(32'h0000_00E2, 1'b1, 1'b1);
    wait_valid("t5_first_beat");
    step();
    gnt_force = 1;
    #1;
    check("t5_valid_drop", bus_valid, 0);
    step();
    check("t5_release", state, RELEASE);
    check("t5_req_low", req, 0);
    gnt_force = 2;
    step();
    check("t5_hold1", state, RELEASE);
    check("t5_hold1_req", req, 0);
    check("t5_hold1_valid", bus_valid, 0);
    step();
    check("t5_hold2", state, RELEASE);
    check("t5_hold2_req", req, 0);
    gnt_force = 0;
    step();
    check("t5_idle", state, IDLE);
    check("t5_idle_req", req, 0);
    step();
    check("t5_rereq", req, 1);
    wait_drain("t5_drain");
    wait_state("t5_idle_end", IDLE);

`ifdef ARB_REQ_TIMEOUT_EN
    // No grant ever: req held exactly REQ_TIMEOUT cycles, then sticky error and retry.
    gnt_force = 1;
    write_word(32'h0000_0F01, 1'b1, 1'b1);
    step();
    begin
      int cycles;
      cycles = 0;
      while (req && cycles < 200) begin
        cycles++;
        step();
      end
      check("to_cycles", cycles, REQ_TIMEOUT);
    end
    check("to_err_set", timeout_err, 1);
    check("to_release", state, RELEASE);
    gnt_force = 0;
    wait_drain("to_retry");
    wait_state("to_idle", IDLE);
    check("to_sticky", timeout_err, 1);
`endif

    // Reset mid-burst: outputs drop at once, buffered words are discarded.
    for (int i = 0; i < 4; i++) write_word(32'h0000_00F0 + i, 1'b0, 1'b0);
    wait_valid("t6_in_burst");
    rst = 1'b1;
    #1;
    check("t6_req", req, 0);
    check("t6_bus_valid", bus_valid, 0);
    check("t6_wr_ready", wr_ready, 1);
    check("t6_state", state, IDLE);
    check("t6_timeout_err", timeout_err, 0);
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t6_fifo_empty", req, 0);
    check("t6_idle", state, IDLE);

    check("end_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
